// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 arrow-key front end.
// Holds scan codes, the frame length, decoder states and the arrow-code lookup.
package ps2_pkg;

  localparam int FRAME_LEN = 11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // bit positions in the 4-bit direction vector
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] mask;
    mask = 4'b0000;
    case (code)
      SC_UP:    mask[KEY_UP]    = 1'b1;
      SC_DOWN:  mask[KEY_DOWN]  = 1'b1;
      SC_LEFT:  mask[KEY_LEFT]  = 1'b1;
      SC_RIGHT: mask[KEY_RIGHT] = 1'b1;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive deframer: pin synchronizers, ps2_clk glitch filter, 11-bit
// shift register, start/stop/odd-parity check and mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(FRAME_LEN);

  logic [1:0]           clk_sync;
  logic [1:0]           data_sync;
  logic [FW-1:0]        filt_cnt;
  logic                 clk_filt;
  logic                 filt_prev;
  logic                 filt_fall;
  logic [FRAME_LEN-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 frame_done;
  logic                 frame_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // filtered clock only moves after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt  <= '0;
      clk_filt  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= clk_filt;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= ~clk_filt;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign filt_fall = filt_prev & ~clk_filt;

  // timeout is a down-counter reloaded on every falling edge and while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      to_cnt     <= TW'(TIMEOUT_CYCLES - 1);
    end else begin
      frame_done <= 1'b0;
      if (filt_fall) begin
        shreg  <= {data_sync[1], shreg[FRAME_LEN-1:1]};
        to_cnt <= TW'(TIMEOUT_CYCLES - 1);
        if (bit_cnt == BW'(FRAME_LEN - 1)) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt == '0) begin
        to_cnt <= TW'(TIMEOUT_CYCLES - 1);
      end else if (to_cnt == '0) begin
        bit_cnt <= '0;
      end else begin
        to_cnt <= to_cnt - 1'b1;
      end
    end
  end

  // start low, stop high, odd parity across data plus parity bit
  assign frame_ok = ~shreg[0] & shreg[FRAME_LEN-1] & (^shreg[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= frame_done & frame_ok;
      rx_err   <= frame_done & ~frame_ok;
      if (frame_done && frame_ok) begin
        rx_data <= shreg[8:1];
      end
    end
  end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow-key decoder: E0/F0 prefix tracking, held direction levels and
// one-cycle press pulses for the cursor logic.
//
//   state      | meaning
//   -----------+----------------------------------------
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 seen, next byte is an extended make
//   ST_BRK     | F0 seen without E0
//   ST_EXT_BRK | E0 and F0 seen, next byte is an extended break
module ps2_arrow_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       left_p,
  output logic       right_p,
  output logic       up_p,
  output logic       down_p
);

  dec_state_t state_q, state_d;
  logic [3:0] lvl_q, lvl_d;
  logic [3:0] lvl_prev_q;
  logic [3:0] pulse_q;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_frame (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      pulse_q    <= lvl_q & ~lvl_prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    if (rx_err) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_d = ST_EXT;
          else if (rx_data == SC_BRK) state_d = ST_BRK;
          else                        state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            lvl_d   = lvl_q | arrow_mask(rx_data);
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_data == SC_EXT) state_d = ST_EXT_BRK;
          else                   state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          lvl_d   = lvl_q & ~arrow_mask(rx_data);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign up      = lvl_q[KEY_UP];
  assign down    = lvl_q[KEY_DOWN];
  assign left    = lvl_q[KEY_LEFT];
  assign right   = lvl_q[KEY_RIGHT];
  assign up_p    = pulse_q[KEY_UP];
  assign down_p  = pulse_q[KEY_DOWN];
  assign left_p  = pulse_q[KEY_LEFT];
  assign right_p = pulse_q[KEY_RIGHT];

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder driven by a time-scaled PS/2 device
// (800-unit bit period, clk period 10, timeout shortened to 200 cycles).
module tb_ps2_arrow_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic       left, right, up, down;
  logic       left_p, right_p, up_p, down_p;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_err = 0;
  int n_up_p = 0, n_down_p = 0, n_left_p = 0, n_right_p = 0;

  ps2_arrow_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .left     (left),
    .right    (right),
    .up       (up),
    .down     (down),
    .left_p   (left_p),
    .right_p  (right_p),
    .up_p     (up_p),
    .down_p   (down_p)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) n_valid++;
      if (rx_err)   n_err++;
      if (up_p)     n_up_p++;
      if (down_p)   n_down_p++;
      if (left_p)   n_left_p++;
      if (right_p)  n_right_p++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      #200;
      ps2_clk = 1'b0;
      #400;
      ps2_clk = 1'b1;
      #200;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_parity);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    send_bits(f, 11);
    #400;
  endtask

  initial begin
    logic [10:0] partial;
    partial = 11'b110_1010_1010;

    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", 32'({rx_data, rx_valid, rx_err, up, down, left, right,
                                up_p, down_p, left_p, right_p}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_outputs", 32'({rx_data, rx_valid, rx_err, up, down, left, right}), 32'h0);

    send_byte(8'h1C, 1'b0);
    check("valid_1c", 32'(n_valid), 32'd1);
    check("data_1c", 32'(rx_data), 32'h1C);
    check("err_1c", 32'(n_err), 32'd0);
    check("levels_1c", 32'({up, down, left, right}), 32'h0);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("up_set", 32'(up), 32'd1);
    check("up_p_once", 32'(n_up_p), 32'd1);
    check("valid_cnt_3", 32'(n_valid), 32'd3);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("up_repeat_hold", 32'(up), 32'd1);
    check("up_repeat_no_pulse", 32'(n_up_p), 32'd1);

    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("up_release", 32'(up), 32'd0);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    check("left_right_both", 32'({left, right}), 32'b11);
    check("left_p_once", 32'(n_left_p), 32'd1);
    check("right_p_once", 32'(n_right_p), 32'd1);

    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check("left_rel_right_hold", 32'({left, right}), 32'b01);
    check("valid_cnt_15", 32'(n_valid), 32'd15);

    send_byte(8'h1C, 1'b1);
    check("err_bad_parity", 32'(n_err), 32'd1);
    check("no_valid_bad_parity", 32'(n_valid), 32'd15);
    check("data_held_on_err", 32'(rx_data), 32'h6B);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h75, 1'b0);
    check("up_after_err", 32'(up), 32'd0);
    check("up_p_after_err", 32'(n_up_p), 32'd1);
    check("err_cnt_2", 32'(n_err), 32'd2);

    send_bits(partial, 5);
    #3000;
    send_byte(8'hE0, 1'b0);
    check("timeout_valid_cnt", 32'(n_valid), 32'd18);
    check("timeout_err_cnt", 32'(n_err), 32'd2);
    check("timeout_data_e0", 32'(rx_data), 32'hE0);

    #500;
    ps2_clk = 1'b0;
    #40;
    ps2_clk = 1'b1;
    #500;
    send_byte(8'h72, 1'b0);
    check("glitch_down_set", 32'(down), 32'd1);
    check("glitch_down_p", 32'(n_down_p), 32'd1);
    check("glitch_valid_cnt", 32'(n_valid), 32'd19);
    check("glitch_err_cnt", 32'(n_err), 32'd2);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_down_clear", 32'(down), 32'd0);
    check("reset_levels", 32'({up, down, left, right}), 32'h0);
    check("reset_pulses", 32'({up_p, down_p, left_p, right_p, rx_valid, rx_err}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
